// File: rtl/xnor_seq_comparator.sv
// -----------------------------------------------------------------------------
// xnor_seq_comparator
//
// Bit-serial equality comparator. A single gate-level xnor_gate cell is shared
// across all bit positions: operands are captured on an accepted start and
// shifted LSB-first through the cell, one bit per clock. The block accumulates
// the equality result and records the lowest differing bit index.
//
// Optional feature macro: XNOR_SEQ_EARLY_EXIT_EN
//   undefined (default) : all WIDTH bits are always processed, fixed latency
//                         of WIDTH+1 edges from the accepting edge to done.
//   defined             : the first mismatching bit ends the run at once;
//                         latency becomes diff_idx+2 edges for unequal
//                         operands, WIDTH+1 edges for equal operands.
//
// Ports
//   clk        in   1      sole clock, rising edge
//   rst_n      in   1      synchronous reset, active low
//   start      in   1      compare request, accepted only in IDLE
//   a, b       in   WIDTH  operands, sampled only on the accepting edge
//   busy       out  1      high while bits are processed (RUN)
//   done       out  1      one-cycle pulse, result valid from this cycle on
//   equal      out  1      1 if all compared bits matched, held until next accept
//   diff_idx   out  IDX_W  lowest differing bit index (0 when equal), held
//   bit_idx    out  IDX_W  bit currently at the XNOR cell, valid while busy
//   state_dbg  out  2      current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is a level request sampled on each rising edge; it is
// accepted on the first edge where the FSM is in IDLE and rst_n is high.
// While busy or done is high, start is ignored, so a requester may hold it.
// A completed compare is signalled by exactly one done cycle; the result
// outputs stay stable from that cycle until the next accepted start.
// Back-to-back compares therefore see one IDLE cycle between done and the
// next accept. WIDTH must be at least 2.
// -----------------------------------------------------------------------------

// Gate-library XNOR cell. Kept as a separate module so the comparator's
// XNOR function comes from exactly one instantiated cell.
module xnor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a ^ b);

endmodule

module xnor_seq_comparator #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [IDX_W-1:0] diff_idx,
  output logic [IDX_W-1:0] bit_idx,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [IDX_W-1:0] cnt;
  logic             acc;
  logic             found;
  logic             x;
  logic             leave_run;

  // The one shared cell: always looks at the current LSBs of the shifters.
  xnor_gate u_xnor (
    .a (sa[0]),
    .b (sb[0]),
    .y (x)
  );

  // Condition for the last RUN edge. With early exit, the first mismatch
  // also ends the run; found is necessarily still clear at that point.
`ifdef XNOR_SEQ_EARLY_EXIT_EN
  assign leave_run = (cnt == LAST_IDX) || !x;
`else
  assign leave_run = (cnt == LAST_IDX);
`endif

  assign bit_idx   = cnt;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      cnt      <= '0;
      acc      <= 1'b0;
      found    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      equal    <= 1'b0;
      diff_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa       <= a;
            sb       <= b;
            cnt      <= '0;
            acc      <= 1'b1;
            found    <= 1'b0;
            equal    <= 1'b0;
            diff_idx <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          acc <= acc & x;
          // Only the first mismatch is recorded, giving the lowest index
          // because bits arrive LSB-first.
          if (!x && !found) begin
            diff_idx <= cnt;
            found    <= 1'b1;
          end
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (leave_run) begin
            // Fold in the final bit directly; acc itself only updates now.
            equal <= acc & x;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          // start is ignored here; the next accept needs an IDLE edge.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/xnor_seq_comparator.md
# xnor_seq_comparator

Bit-serial equality comparator controller that shares a single gate-level `xnor_gate` cell across all bit positions of two WIDTH-bit operands. It captures the operands on a start request and steps them LSB-first through the shared XNOR cell, one bit per clock. It accumulates the equality result and records the lowest differing bit index. It sits between a requester, such as a testbench or register-compare stage, and the gate library, replacing WIDTH parallel XNOR cells with one cell plus sequencing.

## Interface
- `WIDTH`, default 8: operand width in bits. Must be at least 2.
- `IDX_W`, default `$clog2(WIDTH)`: width of the bit-index outputs.

- `clk`  in  1: sole clock, rising-edge.
- `rst_n`  in  1: synchronous reset, active-low. Sampled only on the `clk` rising edge.
- `start`  in  1: request a compare. Accepted only in IDLE.
- `a`  in  WIDTH: operand A. Sampled only on the accepting edge.
- `b`  in  WIDTH: operand B. Sampled only on the accepting edge.
- `busy`  out  1: high while bits are being processed (RUN state).
- `done`  out  1: one-cycle pulse. The result is valid from this cycle on.
- `equal`  out  1: 1 if all compared bits matched. Holds until the next accepted start.
- `diff_idx`  out  IDX_W: index of the lowest differing bit. It is 0 when `equal` is 1. Holds like `equal`.
- `bit_idx`  out  IDX_W: index of the bit currently at the shared XNOR cell. Valid while `busy` is high.

## Operation
- FSM states:
  - IDLE (reset state)
  - RUN
  - DONE
- IDLE:
  - On `start`=1 at an edge: load `a` and `b` into shift registers `sa` and `sb`.
  - Also set the counter to 0, set the equality accumulator to 1, clear the found flag, and clear `equal` and `diff_idx`.
  - Then go to RUN.
- RUN, each edge:
  - The shared `xnor_gate` instance evaluates `x = xnor(sa[0], sb[0])`.
  - Update the accumulator: `acc <= acc & x`.
  - If `x`=0 and the found flag is clear, set `diff_idx <= cnt` and set the found flag.
  - Shift `sa` and `sb` right by one and increment `cnt`.
  - When `cnt == WIDTH-1`, go to DONE.
- DONE:
  - `done`=1 and `equal` = acc.
  - Next edge: go to IDLE.
- The XNOR function must come from the instantiated `xnor_gate` cell. Do not use an RTL `~^` operator. Exactly one instance is allowed.
- `start` in RUN or DONE is ignored. Operand changes after acceptance have no effect.
- Back-to-back compares require one IDLE cycle between the `done` cycle and the next accepted `start`.
- Reset values:
  - `busy`=0, `done`=0, `equal`=0, `diff_idx`=0, `bit_idx`=0
  - state = IDLE
  - `sa`, `sb`, `cnt` = 0

## Timing
- Numbering: `start` is accepted at edge k.
- `busy`:
  - Rises after edge k.
  - RUN spans edges k+1 … k+WIDTH, one bit per edge: bit i is processed at edge k+1+i.
  - Falls after edge k+WIDTH.
- DONE: `done` is high for exactly the cycle after edge k+WIDTH.
- Latency, accepting edge to `done`: WIDTH+1 edges (9 edges for WIDTH=8).
- `equal` and `diff_idx` are registered. They are stable in the `done` cycle and held through IDLE.
- Reset mid-operation: `rst_n`=0 at any edge forces IDLE and all reset values at that edge.
  - No `done` pulse is produced for the aborted compare.
  - `start` is accepted at the first edge where `rst_n`=1.
- `start` and `rst_n`=0 at the same edge: reset wins.

## Configuration
- Macro `XNOR_SEQ_EARLY_EXIT_EN`.
- Defined:
  - In RUN, if `x`=0 at an edge, go directly to DONE with `equal`=0 and `diff_idx` = current `cnt`.
  - Latency becomes diff_idx+2 edges.
  - Equal operands still take WIDTH+1 edges.
- Undefined: all WIDTH bits are always processed. Latency is fixed at WIDTH+1 edges.

## Test plan
All scenarios use WIDTH=8.

- Reset: hold `rst_n`=0 for 2 edges, release, no `start` -> `busy`=0, `done`=0, `equal`=0, `diff_idx`=0 indefinitely.
- Equal operands: `a`=0xA5, `b`=0xA5, `start` pulse -> `busy` high for 8 cycles, then `done` for 1 cycle at 9 edges; `equal`=1, `diff_idx`=0, held after.
- LSB mismatch: `a`=0xA5, `b`=0xA4 -> `equal`=0, `diff_idx`=0.
  - Without the macro: `done` at edge 9.
  - With `XNOR_SEQ_EARLY_EXIT_EN`: `done` at edge 2.
- MSB mismatch plus multiple differences:
  - `a`=0x80, `b`=0x00 -> `equal`=0, `diff_idx`=7, `done` at edge 9 in both builds.
  - `a`=0x0C, `b`=0x00 -> `diff_idx`=2.
- Start while busy: hold `start`=1 continuously and change `a`/`b` to 0xFF/0x00 during RUN.
  - Result reflects the originally captured operands.
  - The next accept occurs only after the DONE→IDLE edge.
- Reset mid-run: assert `rst_n`=0 at RUN edge 4 -> all outputs return to reset values at that edge and no `done` is produced. A fresh compare of 0x3C vs 0x3C then returns `equal`=1 at edge 9.
